// File: rtl/clint_ctrl_pkg.sv
// Shared encodings for the core-local interrupt sequencer: CSR addresses,
// the SYSTEM instructions it traps on, mcause values and the FSM state type.
// Also holds the two mstatus rewrite helpers used on trap entry and mret.
package clint_ctrl_pkg;

  // CSR addresses, zero-extended to the 32-bit write-address bus
  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MTVEC   = 32'h0000_0305;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

  // SYSTEM instruction encodings recognised at ID
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  // mcause values
  localparam logic [31:0] CAUSE_ECALL   = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
  localparam logic [31:0] CAUSE_EXT_INT = 32'h8000_000B;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_MEPC         = 3'd1,
    S_MSTATUS      = 3'd2,
    S_MCAUSE       = 3'd3,
    S_MRET_MSTATUS = 3'd4,
    S_ASSERT       = 3'd5
  } clint_state_e;

  // Trap entry: MPIE <= MIE, MIE <= 0.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
    return {ms[31:8], ms[3], ms[6:4], 1'b0, ms[2:0]};
  endfunction

  // mret: MIE <= MPIE, MPIE <= 1.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
    return {ms[31:8], 1'b1, ms[6:4], ms[7], ms[2:0]};
  endfunction

endpackage

// File: rtl/clint_ctrl.sv
// Core-local interrupt/exception sequencer.
// Detects ecall/ebreak/mret at ID and level external interrupts, holds the
// pipeline while it writes mepc/mstatus/mcause (or mstatus for mret) through
// the CSR file's clint port, then issues a one-cycle redirect.
// Ports:
//   clk, rst            clock, async active-high reset
//   inst_i/inst_addr_i  instruction at ID and its PC
//   jump_flag_i/addr_i  EX redirect (used as epc for interrupts)
//   div_started_i       divide in flight, defers interrupts
//   int_flag_i          external interrupt request lines (level)
//   csr_*_i             mtvec/mepc/mstatus from CSR file
//   global_int_en_i     mstatus.MIE
//   hold_flag_o         pipeline stall
//   we_o/waddr_o/data_o CSR write port
//   int_assert_o/int_addr_o  redirect strobe and target
module clint_ctrl
  import clint_ctrl_pkg::*;
#(
  parameter int unsigned IRQ_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      inst_addr_i,
  input  logic             jump_flag_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             div_started_i,
  input  logic [IRQ_W-1:0] int_flag_i,
  input  logic [31:0]      csr_mtvec_i,
  input  logic [31:0]      csr_mepc_i,
  input  logic [31:0]      csr_mstatus_i,
  input  logic             global_int_en_i,
  output logic             hold_flag_o,
  output logic             we_o,
  output logic [31:0]      waddr_o,
  output logic [31:0]      data_o,
  output logic             int_assert_o,
  output logic [31:0]      int_addr_o
);

  clint_state_e state_q, state_d;
  logic [31:0]  cause_q, cause_d;
  logic [31:0]  epc_q, epc_d;
  logic         mret_q, mret_d;   // redirect target select for S_ASSERT
  logic         hold;
  logic         irq_req;

  // Interrupts wait for an in-flight divide to finish rather than abort it.
  assign irq_req = (|int_flag_i) && global_int_en_i && !div_started_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cause_q <= '0;
      epc_q   <= '0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      mret_q  <= mret_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    epc_d        = epc_q;
    mret_d       = mret_q;
    hold         = 1'b0;
    we_o         = 1'b0;
    waddr_o      = '0;
    data_o       = '0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;

    unique case (state_q)
      S_IDLE: begin
        // Synchronous events outrank the interrupt; a pending interrupt
        // stays level and is reconsidered once back in idle.
        if (inst_i == INST_ECALL) begin
          hold    = 1'b1;
          state_d = S_MEPC;
          cause_d = CAUSE_ECALL;
          epc_d   = inst_addr_i;
          mret_d  = 1'b0;
        end else if (inst_i == INST_EBREAK) begin
          hold    = 1'b1;
          state_d = S_MEPC;
          cause_d = CAUSE_EBREAK;
          epc_d   = inst_addr_i;
          mret_d  = 1'b0;
        end else if (inst_i == INST_MRET) begin
          hold    = 1'b1;
          state_d = S_MRET_MSTATUS;
          mret_d  = 1'b1;
        end else if (irq_req) begin
          hold    = 1'b1;
          state_d = S_MEPC;
          cause_d = CAUSE_EXT_INT;
          // Resume at the EX redirect target if one is being taken now.
          epc_d   = jump_flag_i ? jump_addr_i : inst_addr_i;
          mret_d  = 1'b0;
        end
      end
      S_MEPC: begin
        hold    = 1'b1;
        we_o    = 1'b1;
        waddr_o = CSR_MEPC;
        data_o  = epc_q;
        state_d = S_MSTATUS;
      end
      S_MSTATUS: begin
        hold    = 1'b1;
        we_o    = 1'b1;
        waddr_o = CSR_MSTATUS;
        data_o  = trap_mstatus(csr_mstatus_i);
        state_d = S_MCAUSE;
      end
      S_MCAUSE: begin
        hold    = 1'b1;
        we_o    = 1'b1;
        waddr_o = CSR_MCAUSE;
        data_o  = cause_q;
        state_d = S_ASSERT;
      end
      S_MRET_MSTATUS: begin
        hold    = 1'b1;
        we_o    = 1'b1;
        waddr_o = CSR_MSTATUS;
        data_o  = mret_mstatus(csr_mstatus_i);
        state_d = S_ASSERT;
      end
      S_ASSERT: begin
        hold         = 1'b1;
        int_assert_o = 1'b1;
        int_addr_o   = mret_q ? csr_mepc_i : csr_mtvec_i;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Idle-state detection is combinational; mask it so reset forces a quiet bus.
  assign hold_flag_o = hold && !rst;

endmodule

// File: tb/tb_clint_ctrl.sv
// Self-checking bench for clint_ctrl: a small CSR-file stand-in absorbs the
// DUT's writes, a schedule-based reference model predicts every output on
// every cycle, and directed scenarios pin the model with literal values.
module tb_clint_ctrl;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = NOP, inst_addr = '0;
  logic        jump_flag = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        div_started = 1'b0;
  logic [7:0]  int_flag = '0;
  logic [31:0] mtvec = '0, mepc = '0, mstatus = '0, mcause = '0;
  logic        gie;
  logic        hold, we, int_assert;
  logic [31:0] waddr, wdata, int_addr;

  assign gie = mstatus[3];

  always #5 clk = ~clk;

  clint_ctrl #(.IRQ_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .inst_i         (inst),
    .inst_addr_i    (inst_addr),
    .jump_flag_i    (jump_flag),
    .jump_addr_i    (jump_addr),
    .div_started_i  (div_started),
    .int_flag_i     (int_flag),
    .csr_mtvec_i    (mtvec),
    .csr_mepc_i     (mepc),
    .csr_mstatus_i  (mstatus),
    .global_int_en_i(gie),
    .hold_flag_o    (hold),
    .we_o           (we),
    .waddr_o        (waddr),
    .data_o         (wdata),
    .int_assert_o   (int_assert),
    .int_addr_o     (int_addr)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: kind 0 idle, 1 trap (4 steps), 2 mret (2 steps).
  int          m_kind = 0;
  int          m_step = 0;
  logic [31:0] m_cause = '0, m_epc = '0;

  // Observation log for directed checks.
  int          hold_cnt, assert_cnt;
  logic [31:0] last_assert_addr;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr_log();
    hold_cnt = 0;
    assert_cnt = 0;
    last_assert_addr = '0;
    wr_addr.delete();
    wr_data.delete();
  endtask

  // One clock: check at negedge, clock the CSR stand-in and model, inputs
  // may change 1 time unit after the posedge.
  task automatic step();
    logic        e_hold, e_we, e_as;
    logic [31:0] e_wa, e_wd, e_ia;
    logic        sync_ev, async_ev;
    int          n_kind, n_step;
    logic [31:0] n_cause, n_epc;
    logic        s_we;
    logic [31:0] s_wa, s_wd;

    @(negedge clk);
    e_hold = 0; e_we = 0; e_as = 0; e_wa = 0; e_wd = 0; e_ia = 0;
    n_kind = m_kind; n_step = m_step; n_cause = m_cause; n_epc = m_epc;
    if (rst) begin
      n_kind = 0;
    end else if (m_kind == 0) begin
      sync_ev  = (inst == ECALL) || (inst == EBREAK) || (inst == MRET);
      async_ev = (int_flag != 0) && gie && !div_started;
      e_hold = sync_ev || async_ev;
      n_step = 1;
      if (inst == ECALL) begin
        n_kind = 1; n_cause = 11; n_epc = inst_addr;
      end else if (inst == EBREAK) begin
        n_kind = 1; n_cause = 3; n_epc = inst_addr;
      end else if (inst == MRET) begin
        n_kind = 2;
      end else if (async_ev) begin
        n_kind = 1; n_cause = 32'h8000_000B;
        n_epc = jump_flag ? jump_addr : inst_addr;
      end
    end else begin
      e_hold = 1;
      if (m_kind == 1) begin
        case (m_step)
          1: begin e_we = 1; e_wa = 32'h341; e_wd = m_epc; end
          2: begin
            e_we = 1; e_wa = 32'h300;
            e_wd = (mstatus & ~32'h88) | (mstatus[3] ? 32'h80 : 32'h0);
          end
          3: begin e_we = 1; e_wa = 32'h342; e_wd = m_cause; end
          default: begin e_as = 1; e_ia = mtvec; end
        endcase
        if (m_step == 4) n_kind = 0; else n_step = m_step + 1;
      end else begin
        if (m_step == 1) begin
          e_we = 1; e_wa = 32'h300;
          e_wd = (mstatus & ~32'h88) | 32'h80 | (mstatus[7] ? 32'h8 : 32'h0);
          n_step = 2;
        end else begin
          e_as = 1; e_ia = mepc; n_kind = 0;
        end
      end
    end

    chk("hold", {31'b0, hold}, {31'b0, e_hold});
    chk("we", {31'b0, we}, {31'b0, e_we});
    chk("int_assert", {31'b0, int_assert}, {31'b0, e_as});
    if (e_we) begin
      chk("waddr", waddr, e_wa);
      chk("wdata", wdata, e_wd);
    end
    if (e_as || rst) chk("int_addr", int_addr, e_ia);

    if (!rst) begin
      if (hold) hold_cnt++;
      if (int_assert) begin
        assert_cnt++;
        last_assert_addr = int_addr;
      end
      if (we) begin
        wr_addr.push_back(waddr);
        wr_data.push_back(wdata);
      end
    end
    s_we = we && !rst; s_wa = waddr; s_wd = wdata;

    @(posedge clk);
    if (s_we) begin
      case (s_wa[11:0])
        12'h300: mstatus = s_wd;
        12'h341: mepc    = s_wd;
        12'h342: mcause  = s_wd;
        default: ;
      endcase
    end
    m_kind = n_kind; m_step = n_step; m_cause = n_cause; m_epc = n_epc;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_wr(input int idx, input logic [31:0] a, input logic [31:0] d);
    if (wr_addr.size() > idx) begin
      chk("log_waddr", wr_addr[idx], a);
      chk("log_wdata", wr_data[idx], d);
    end else begin
      chk("log_count", wr_addr.size(), idx + 1);
    end
  endtask

  initial begin
    int r;
    clr_log();

    // Reset state
    #1;
    chk("rst_hold", {31'b0, hold}, 32'd0);
    chk("rst_int_addr", int_addr, 32'd0);
    run(2);
    rst = 1'b0;
    run(2);

    // ecall
    mstatus = 32'h8; mtvec = 32'h200;
    inst = ECALL; inst_addr = 32'h100;
    clr_log();
    step();
    inst = NOP;
    run(5);
    chk("ecall_hold_cycles", hold_cnt, 5);
    chk_wr(0, 32'h341, 32'h100);
    chk_wr(1, 32'h300, 32'h80);
    chk_wr(2, 32'h342, 32'd11);
    chk("ecall_assert_cnt", assert_cnt, 1);
    chk("ecall_vector", last_assert_addr, 32'h200);

    // mret
    mepc = 32'h104; mstatus = 32'h80;
    inst = MRET;
    clr_log();
    step();
    inst = NOP;
    run(3);
    chk("mret_hold_cycles", hold_cnt, 3);
    chk_wr(0, 32'h300, 32'h88);
    chk("mret_target", last_assert_addr, 32'h104);

    // Interrupt during EX redirect
    mstatus = 32'h8; int_flag = 8'h01; jump_flag = 1'b1; jump_addr = 32'h300;
    inst_addr = 32'h180;
    clr_log();
    step();
    int_flag = '0; jump_flag = 1'b0;
    run(5);
    chk_wr(0, 32'h341, 32'h300);
    chk_wr(2, 32'h342, 32'h8000_000B);

    // Interrupt masked
    mstatus = 32'h0; int_flag = 8'h01;
    clr_log();
    run(4);
    chk("masked_hold_cycles", hold_cnt, 0);
    int_flag = '0;

    // Deferred by divide
    mstatus = 32'h8; int_flag = 8'h01; div_started = 1'b1;
    clr_log();
    run(5);
    chk("div_hold_cycles", hold_cnt, 0);
    div_started = 1'b0;
    step();
    chk("div_fall_hold", hold_cnt, 1);
    int_flag = '0;
    run(5);

    // ebreak with a pending interrupt
    mstatus = 32'h8; mtvec = 32'h400; int_flag = 8'h01;
    inst = EBREAK; inst_addr = 32'h140;
    clr_log();
    step();
    inst = NOP;
    run(10);
    chk("ebreak_hold_cycles", hold_cnt, 5);
    chk_wr(2, 32'h342, 32'd3);
    int_flag = '0;

    // Reset mid-sequence
    mstatus = 32'h8; inst = ECALL; inst_addr = 32'h100;
    clr_log();
    step();
    inst = NOP;
    step();
    rst = 1'b1;
    #1;
    chk("midrst_hold", {31'b0, hold}, 32'd0);
    chk("midrst_we", {31'b0, we}, 32'd0);
    chk("midrst_waddr", waddr, 32'd0);
    chk("midrst_data", wdata, 32'd0);
    run(2);
    rst = 1'b0;
    clr_log();
    run(6);
    chk("midrst_no_assert", assert_cnt, 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 4)       inst = ECALL;
      else if (r < 8)  inst = EBREAK;
      else if (r < 12) inst = MRET;
      else if (r < 20) inst = $urandom;
      else             inst = NOP;
      inst_addr   = $urandom & 32'hFFFF_FFFC;
      jump_flag   = ($urandom_range(0, 4) == 0);
      jump_addr   = $urandom & 32'hFFFF_FFFC;
      div_started = ($urandom_range(0, 4) == 0);
      int_flag    = ($urandom_range(0, 9) < 3) ? 8'($urandom_range(1, 255)) : 8'h00;
      if ($urandom_range(0, 19) == 0) mstatus = $urandom;
      if ($urandom_range(0, 19) == 0) mtvec = $urandom;
      if ($urandom_range(0, 19) == 0) mepc = $urandom;
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    run(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
